axicb_fifo_reader: RTL and testbench

- Read-side front end that drains a pull/empty FIFO read port into a registered valid/ready master channel.
- Instantiated after each crossbar channel FIFO.
- A 2-entry output buffer (head plus skid) sustains 1 beat/cycle.
- No combinational path from m_ready to fifo_pull.

---
 rtl/axicb_pkg.sv | 15 +
 rtl/axicb_fifo_reader.sv | 99 +++++++++
 tb/tb_axicb_fifo_reader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axicb_pkg.sv
// Shared crossbar definitions: output-buffer occupancy encodings and a
// helper that computes the next occupancy from pull/pop strobes.
package axicb_pkg;

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  function automatic logic [1:0] cnt_step(input logic [1:0] cnt,
                                          input logic       pull,
                                          input logic       pop);
    return cnt + 2'(pull) - 2'(pop);
  endfunction

endpackage

// File: rtl/axicb_fifo_reader.sv
// Drains a pull/empty FIFO read port into a registered valid/ready channel
// through a head+skid buffer. Define AXICB_FIFO_READER_STATS_EN for counters.
module axicb_fifo_reader
  import axicb_pkg::*;
#(
  parameter int DATA_WIDTH = 8
`ifdef AXICB_FIFO_READER_STATS_EN
  , parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_pull,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef AXICB_FIFO_READER_STATS_EN
  , output logic [STAT_WIDTH-1:0] beat_cnt,
  output logic [STAT_WIDTH-1:0] stall_cnt
`endif
);

  logic [1:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  pull;
  logic                  pop;

  assign m_valid   = (count_q != CNT_EMPTY);
  assign m_data    = buf0_q;
  assign fifo_pull = pull;

  // Pull looks only at registered occupancy, so m_ready never reaches it.
  always_comb begin
    pull = ~fifo_empty & ~flush & ~srst & (count_q != CNT_FULL);
    pop  = m_valid & m_ready;
  end

  always_comb begin
    count_d = flush ? CNT_EMPTY : cnt_step(count_q, pull, pop);
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    case (count_q)
      CNT_EMPTY: begin
        if (pull) buf0_d = fifo_data;
      end
      CNT_ONE: begin
        if (pull && !pop)     buf1_d = fifo_data;
        else if (pull && pop) buf0_d = fifo_data;
      end
      CNT_FULL: begin
        if (pop) buf0_d = buf1_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      count_q <= CNT_EMPTY;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      count_q <= count_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

`ifdef AXICB_FIFO_READER_STATS_EN
  logic [STAT_WIDTH-1:0] beat_q, beat_d;
  logic [STAT_WIDTH-1:0] stall_q, stall_d;

  // Saturating counters; flush deliberately leaves them alone.
  always_comb begin
    beat_d  = beat_q;
    stall_d = stall_q;
    if (pop && (beat_q != '1))                 beat_d  = beat_q + STAT_WIDTH'(1);
    if (m_valid && !m_ready && (stall_q != '1)) stall_d = stall_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      beat_q  <= beat_d;
      stall_q <= stall_d;
    end
  end

  assign beat_cnt  = beat_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_axicb_fifo_reader.sv
// Self-checking bench for axicb_fifo_reader against a queue-based model of
// the source FIFO and the two-deep output buffer.
module tb_axicb_fifo_reader;

  logic       aclk = 1'b0;
  logic       srst;
  logic       flush;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_pull;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

`ifdef AXICB_FIFO_READER_STATS_EN
  logic [15:0] beat_cnt, stall_cnt;
  logic [1:0]  w2_beat, w2_stall;
  logic        w2_pull, w2_valid;
  logic [7:0]  w2_data;

  axicb_fifo_reader #(.DATA_WIDTH(8), .STAT_WIDTH(16)) u_dut (
    .aclk(aclk), .srst(srst), .flush(flush), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_pull(fifo_pull), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .beat_cnt(beat_cnt), .stall_cnt(stall_cnt));

  axicb_fifo_reader #(.DATA_WIDTH(8), .STAT_WIDTH(2)) u_dut_w2 (
    .aclk(aclk), .srst(srst), .flush(flush), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_pull(w2_pull), .m_valid(w2_valid),
    .m_ready(m_ready), .m_data(w2_data), .beat_cnt(w2_beat), .stall_cnt(w2_stall));
`else
  axicb_fifo_reader #(.DATA_WIDTH(8)) u_dut (
    .aclk(aclk), .srst(srst), .flush(flush), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_pull(fifo_pull), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data));
`endif

  // Reference model: source FIFO contents, buffered words, raw event counts.
  logic [7:0] src_q[$];
  logic [7:0] mq[$];
  int         beat_m, stall_m;
  logic       exp_pull, exp_valid, exp_pop;
  logic [7:0] exp_data;

  task automatic refresh();
    fifo_empty = (src_q.size() == 0);
    fifo_data  = (src_q.size() == 0) ? 8'($urandom) : src_q[0];
  endtask

  task automatic load(input logic [7:0] w);
    src_q.push_back(w);
    refresh();
  endtask

  // Called mid-low-phase once the inputs for this cycle are in place.
  task automatic predict();
    #1;
    exp_pull  = (src_q.size() != 0) && !flush && !srst && (mq.size() < 2);
    exp_valid = (mq.size() != 0);
    exp_data  = (mq.size() != 0) ? mq[0] : 8'h00;
    exp_pop   = exp_valid && m_ready;
  endtask

  task automatic cycle();
    logic p   = exp_pull;
    logic pp  = exp_pop;
    logic r   = srst;
    logic f   = flush;
    logic stl = exp_valid && !m_ready;
    @(posedge aclk);
    #1;
    if (r) begin
      mq.delete();
      src_q.delete();
      beat_m  = 0;
      stall_m = 0;
    end else begin
      if (pp) begin
        beat_m++;
        void'(mq.pop_front());
      end
      if (stl) stall_m++;
      if (p) mq.push_back(src_q.pop_front());
      if (f) mq.delete();
    end
    refresh();
    @(negedge aclk);
  endtask

  task automatic test_reset();
    srst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    load(8'h3C);
    predict();
    cycle();
    predict();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %02h want 00", m_data); end
    load(8'h3C);
    predict();
    n_cmp++; if (fifo_pull !== exp_pull) begin n_bad++; $display("FAIL reset_pull: got %0b want %0b", fifo_pull, exp_pull); end
    cycle();
  endtask

  task automatic test_latency();
    srst = 1'b0; m_ready = 1'b1;
    src_q.delete();
    load(8'hA5);
    predict();
    n_cmp++; if (fifo_pull !== 1'b1) begin n_bad++; $display("FAIL lat_pull0: got %0b want 1", fifo_pull); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL lat_valid0: got %0b want 0", m_valid); end
    cycle();
    predict();
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid1: got %0b want 1", m_valid); end
    n_cmp++; if (m_data !== 8'hA5) begin n_bad++; $display("FAIL lat_data1: got %02h want a5", m_data); end
    n_cmp++; if (fifo_pull !== exp_pull) begin n_bad++; $display("FAIL lat_pull1: got %0b want %0b", fifo_pull, exp_pull); end
    cycle();
    predict();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL lat_valid2: got %0b want 0", m_valid); end
    cycle();
  endtask

  task automatic test_streaming();
    logic [7:0] got[$];
    int first = -1, last = -1;
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) load(8'(i));
    for (int c = 0; c < 30; c++) begin
      predict();
      n_cmp++; if (fifo_pull !== exp_pull) begin n_bad++; $display("FAIL stream_pull c%0d: got %0b want %0b", c, fifo_pull, exp_pull); end
      n_cmp++; if (m_valid !== exp_valid) begin n_bad++; $display("FAIL stream_valid c%0d: got %0b want %0b", c, m_valid, exp_valid); end
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        if (first < 0) first = c;
        last = c;
      end
      cycle();
    end
    n_cmp++; if (got.size() != 16) begin n_bad++; $display("FAIL stream_count: got %0d want 16", got.size()); end
    n_cmp++; if (last - first != 15) begin n_bad++; $display("FAIL stream_bubble: span %0d want 15", last - first); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_cmp++; if (got[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL stream_data[%0d]: got %02h want %02h", i, got[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got[$];
    logic [7:0] want[3] = '{8'h11, 8'h22, 8'h33};
    int pulls = 0;
    m_ready = 1'b0;
    load(8'h11); load(8'h22); load(8'h33);
    for (int c = 0; c < 6; c++) begin
      predict();
      n_cmp++; if (fifo_pull !== exp_pull) begin n_bad++; $display("FAIL bp_pull c%0d: got %0b want %0b", c, fifo_pull, exp_pull); end
      if (c >= 2) begin
        n_cmp++; if (m_data !== 8'h11) begin n_bad++; $display("FAIL bp_hold c%0d: got %02h want 11", c, m_data); end
      end
      if (fifo_pull) pulls++;
      cycle();
    end
    n_cmp++; if (pulls != 2) begin n_bad++; $display("FAIL bp_pulls: got %0d want 2", pulls); end
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %0b want 1", m_valid); end
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      predict();
      if (m_valid && m_ready) got.push_back(m_data);
      cycle();
    end
    n_cmp++; if (got.size() != 3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_cmp++; if (got[i] !== want[i]) begin n_bad++; $display("FAIL bp_order[%0d]: got %02h want %02h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] got[$];
    m_ready = 1'b0;
    load(8'h44); load(8'h55); load(8'h66);
    for (int c = 0; c < 3; c++) begin predict(); cycle(); end
    flush = 1'b1;
    predict();
    n_cmp++; if (fifo_pull !== 1'b0) begin n_bad++; $display("FAIL flush_pull: got %0b want 0", fifo_pull); end
    n_cmp++; if (m_data !== 8'h44) begin n_bad++; $display("FAIL flush_head: got %02h want 44", m_data); end
    cycle();
    flush = 1'b0;
    predict();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %0b want 0", m_valid); end
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      predict();
      if (m_valid && m_ready) got.push_back(m_data);
      cycle();
    end
    n_cmp++; if (got.size() != 1) begin n_bad++; $display("FAIL flush_count: got %0d want 1", got.size()); end
    if (got.size() > 0) begin
      n_cmp++; if (got[0] !== 8'h66) begin n_bad++; $display("FAIL flush_next: got %02h want 66", got[0]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] got[$];
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) load(8'h80 + 8'(i));
    for (int c = 0; c < 4; c++) begin predict(); cycle(); end
    srst = 1'b1;
    predict();
    n_cmp++; if (fifo_pull !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pull_during: got %0b want 0", fifo_pull); end
    cycle();
    srst = 1'b0;
    predict();
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %0b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL rst_mid_data: got %02h want 00", m_data); end
    n_cmp++; if (fifo_pull !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pull: got %0b want 0", fifo_pull); end
    load(8'hC0); load(8'hC1);
    for (int c = 0; c < 6; c++) begin
      predict();
      if (m_valid && m_ready) got.push_back(m_data);
      cycle();
    end
    n_cmp++; if (got.size() != 2) begin n_bad++; $display("FAIL rst_mid_count: got %0d want 2", got.size()); end
    if (got.size() == 2) begin
      n_cmp++; if (got[0] !== 8'hC0 || got[1] !== 8'hC1) begin n_bad++; $display("FAIL rst_mid_order: got %02h %02h want c0 c1", got[0], got[1]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && src_q.size() < 6) load(8'($urandom));
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 19) == 0);
      srst    = ($urandom_range(0, 59) == 0);
      predict();
      n_cmp++; if (fifo_pull !== exp_pull) begin n_bad++; $display("FAIL rnd_pull c%0d: got %0b want %0b", c, fifo_pull, exp_pull); end
      n_cmp++; if (m_valid !== exp_valid) begin n_bad++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, m_valid, exp_valid); end
      if (exp_valid) begin
        n_cmp++; if (m_data !== exp_data) begin n_bad++; $display("FAIL rnd_data c%0d: got %02h want %02h", c, m_data, exp_data); end
      end
`ifdef AXICB_FIFO_READER_STATS_EN
      n_cmp++; if (beat_cnt !== 16'(beat_m)) begin n_bad++; $display("FAIL rnd_beat c%0d: got %0d want %0d", c, beat_cnt, beat_m); end
      n_cmp++; if (stall_cnt !== 16'(stall_m)) begin n_bad++; $display("FAIL rnd_stall c%0d: got %0d want %0d", c, stall_cnt, stall_m); end
      n_cmp++; if (w2_beat !== 2'((beat_m > 3) ? 3 : beat_m)) begin n_bad++; $display("FAIL rnd_beat_w2 c%0d: got %0d want sat(%0d)", c, w2_beat, beat_m); end
`endif
      cycle();
    end
    srst = 1'b0; flush = 1'b0;
  endtask

`ifdef AXICB_FIFO_READER_STATS_EN
  task automatic test_stats();
    srst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    predict(); cycle();
    srst = 1'b0;
    for (int i = 0; i < 5; i++) load(8'hD0 + 8'(i));
    for (int c = 0; c < 4; c++) begin predict(); cycle(); end
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin predict(); cycle(); end
    predict();
    n_cmp++; if (beat_cnt !== 16'd5) begin n_bad++; $display("FAIL stats_beat: got %0d want 5", beat_cnt); end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL stats_stall: got %0d want 3", stall_cnt); end
    n_cmp++; if (w2_beat !== 2'd3) begin n_bad++; $display("FAIL stats_beat_sat: got %0d want 3", w2_beat); end
    n_cmp++; if (w2_stall !== 2'd3) begin n_bad++; $display("FAIL stats_stall_w2: got %0d want 3", w2_stall); end
    flush = 1'b1;
    predict(); cycle();
    flush = 1'b0;
    predict();
    n_cmp++; if (beat_cnt !== 16'd5) begin n_bad++; $display("FAIL stats_flush_keep: got %0d want 5", beat_cnt); end
    cycle();
  endtask
`endif

  initial begin
    srst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    refresh();
    @(negedge aclk);
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_midstream();
`ifdef AXICB_FIFO_READER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "time limit");
  end

endmodule
